i3c_target_sdr_responder: RTL
=============================

# i3c_target_sdr_responder

Target-side SDR front end that answers the controller's bus-initialisation sequence. It oversamples SCL/SDA on the system clock and detects START, Repeated START and STOP. It receives the address header and ACKs the broadcast address 7'h7E or the target's own dynamic address. After a broadcast write it receives the CCC byte and its T-bit, and flags ENTHDR0 so the target's HDR-DDR engine can take over the bus. It sits beside the target's SDA open-drain pad, mirroring the controller's CCC/SDR path.

## Interface
- TGT_DYN_ADDR, 7'h08, own dynamic address; ACKed for read or write.
- ENTHDR0_CODE, 8'h20, CCC code that triggers HDR-DDR entry.
- SYNC_STAGES, 2, synchroniser depth on i_scl/i_sda; legal values ≥ 2.
- i_sdr_clk  in  1  system clock; at least 8× the SCL rate.
- i_sdr_rst_n  in  1  reset, synchronous, active-low.
- i_tgt_en  in  1  block enable. Low forces IDLE and releases SDA.
- i_scl  in  1  SCL pin, asynchronous.
- i_sda  in  1  resolved SDA bus value, asynchronous.
- i_hdr_exit  in  1  one-cycle pulse from the HDR engine; returns the block to IDLE.
- o_sda_pull_low  out  1  open-drain control; 1 drives SDA low.
- o_start_det  out  1  pulse on START or Repeated START.
- o_stop_det  out  1  pulse on STOP.
- o_addr_valid  out  1  pulse when an ACKed header completes.
- o_addr  out  7  last received address; held until the next header.
- o_rnw  out  1  R/W bit of the last header.
- o_ccc_valid  out  1  pulse when a CCC byte passes its T-bit check.
- o_ccc_code  out  8  last CCC code.
- o_parity_err  out  1  pulse when the T-bit check fails.
- o_hdr_ddr_enter  out  1  pulse when ENTHDR0 is accepted.
- o_in_hdr  out  1  high while in the HDR state.

## Operation
- States: IDLE, ADDR, ACK, CCC, TBIT, WAIT_STOP, HDR.
- Synchronisation and edge detection:
  - i_scl and i_sda each pass through SYNC_STAGES flops, then one edge-detect register.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Data bits are sampled on each synchronised SCL rising edge, MSB first.
- IDLE: START → ADDR, with the bit counter cleared.
- ADDR: shifts in 8 bits {addr[6:0], rnw}.
  - Match means addr equals 7'h7E with rnw=0, or addr equals TGT_DYN_ADDR.
  - Match → ACK. o_addr_valid pulses on the SCL falling edge that ends the 9th bit.
  - No match → WAIT_STOP, SDA never driven.
- ACK: o_sda_pull_low held for the whole 9th bit.
  - 9th-bit end on a broadcast write → CCC.
  - 9th-bit end on any other header → WAIT_STOP. Private data phases are out of scope.
- CCC: shifts 8 bits, then → TBIT.
- TBIT: samples T; required value is odd parity, T = ~^code.
  - T correct → o_ccc_valid pulses and o_ccc_code updates.
  - T correct and code == ENTHDR0_CODE → o_hdr_ddr_enter pulses in the same cycle, then → HDR.
  - T correct, any other code → WAIT_STOP.
  - T wrong → o_parity_err pulses, o_ccc_code is not updated, then → WAIT_STOP.
- WAIT_STOP: STOP → IDLE; Repeated START → ADDR.
- HDR: ignores SCL/SDA events. Stays until i_hdr_exit, then → IDLE.
- START or STOP in any non-HDR state aborts the frame:
  - START → ADDR; STOP → IDLE.
  - o_sda_pull_low is released the same cycle.

## Timing
- Reset values: all outputs 0 and state IDLE. o_addr, o_ccc_code and o_rnw are 0.
- Detect latency: a pin edge produces its event or sample SYNC_STAGES+1 cycles later (3 with the default).
- ACK drive window:
  - Asserts the cycle after the synchronised SCL fall that ends bit 8.
  - Releases the cycle after the synchronised SCL fall that ends bit 9.
  - SDA is therefore never changed while SCL is synchronised high.
- Pulse width: every *_valid, *_det, *_err and *_enter output is exactly one clock wide.
- Precedence within a cycle, highest first: !i_sdr_rst_n, then !i_tgt_en, then i_hdr_exit, then START/STOP, then the bit sample.
- i_tgt_en falling during ACK: o_sda_pull_low is 0 on the next clock.

## Structure
- Shared package i3c_pkg holds:
  - the state enum;
  - I3C_BCAST_ADDR = 7'h7E;
  - CCC code constants, with ENTHDR0 = 8'h20.
- One sub-module, i3c_bus_cond_detect: synchronisers, edge detect, and the start/stop/scl_rise/scl_fall pulses. It is reusable by the SDR target data path.

## Test plan
- START, then 0xFC, then 0x20 with T=0, then SCL stays low → responder ACKs. Checks:
  - o_addr_valid with o_addr=7'h7E, o_rnw=0.
  - o_ccc_valid with o_ccc_code=8'h20.
  - o_hdr_ddr_enter pulse, then o_in_hdr=1 until i_hdr_exit.
- START, then 0x11 (addr 7'h08, read) → ACK, o_rnw=1, then WAIT_STOP. STOP → o_stop_det, state IDLE.
- START, then 0xA0 → no ACK, so o_sda_pull_low stays 0 throughout; STOP → IDLE.
- Broadcast header, then CCC 0x20 with T=1 → o_parity_err pulse, no o_ccc_valid, no HDR entry, o_ccc_code unchanged.
- Repeated START injected at bit 4 of the CCC byte → o_start_det pulse, state ADDR, next 0xFC ACKed normally.
- i_tgt_en deasserted mid-ACK → o_sda_pull_low is 0 one clock later and state is IDLE. Synchronous reset mid-frame → all outputs 0 on the next edge.

Source files
------------

// File: rtl/i3c_pkg.sv
// Shared I3C SDR target definitions: FSM states,
// bus addresses, CCC codes and the T-bit rule.
package i3c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ACK,
      ST_CCC,
      ST_TBIT,
      ST_WAIT_STOP,
      ST_HDR
   } state_t;

   localparam logic [6:0] I3C_BCAST_ADDR = 7'h7E;

   localparam logic [7:0] CCC_RSTDAA  = 8'h06;
   localparam logic [7:0] CCC_ENTDAA  = 8'h07;
   localparam logic [7:0] CCC_ENTHDR0 = 8'h20;

   // T-bit carries odd parity over the CCC byte
   function automatic logic tbit_ok(
      input logic [7:0] code,
      input logic       t
   );
      return t == ~^code;
   endfunction

endpackage

// File: rtl/i3c_bus_cond_detect.sv
// SCL/SDA synchroniser and edge detector producing
// START, STOP and SCL edge pulses.
module i3c_bus_cond_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_pin,
   input  logic sda_pin,
   output logic sda,
   output logic start,
   output logic stop,
   output logic scl_rise,
   output logic scl_fall
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_q;
   logic                   sda_q;
   logic                   scl;

   // Synchronise pins; reset to idle-high to avoid false events
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_pin};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_pin};
         scl_q    <= scl_sync[SYNC_STAGES-1];
         sda_q    <= sda_sync[SYNC_STAGES-1];
      end
   end

   assign scl      = scl_sync[SYNC_STAGES-1];
   assign sda      = sda_sync[SYNC_STAGES-1];
   assign start    = scl & scl_q & sda_q & ~sda;
   assign stop     = scl & scl_q & ~sda_q & sda;
   assign scl_rise = scl & ~scl_q;
   assign scl_fall = ~scl & scl_q;

endmodule

// File: rtl/i3c_target_sdr_responder.sv
// I3C SDR target front end: header ACK, CCC capture
// and ENTHDR0 hand-off to the HDR-DDR engine.
module i3c_target_sdr_responder
   import i3c_pkg::*;
#(
   parameter logic [6:0] TGT_DYN_ADDR = 7'h08,
   parameter logic [7:0] ENTHDR0_CODE = CCC_ENTHDR0,
   parameter int         SYNC_STAGES  = 2
) (
   input  logic       i_sdr_clk,
   input  logic       i_sdr_rst_n,
   input  logic       i_tgt_en,
   input  logic       i_scl,
   input  logic       i_sda,
   input  logic       i_hdr_exit,
   output logic       o_sda_pull_low,
   output logic       o_start_det,
   output logic       o_stop_det,
   output logic       o_addr_valid,
   output logic [6:0] o_addr,
   output logic       o_rnw,
   output logic       o_ccc_valid,
   output logic [7:0] o_ccc_code,
   output logic       o_parity_err,
   output logic       o_hdr_ddr_enter,
   output logic       o_in_hdr
);

   state_t     state;
   logic [3:0] cnt;
   logic [7:0] shreg;
   logic       sda;
   logic       start;
   logic       stop;
   logic       scl_rise;
   logic       scl_fall;
   logic       match;
   logic       bcast_wr;

   i3c_bus_cond_detect #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_det (
      .clk      (i_sdr_clk),
      .rst_n    (i_sdr_rst_n),
      .scl_pin  (i_scl),
      .sda_pin  (i_sda),
      .sda      (sda),
      .start    (start),
      .stop     (stop),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall)
   );

   assign match = ((shreg[7:1] == I3C_BCAST_ADDR) && !shreg[0])
                || (shreg[7:1] == TGT_DYN_ADDR);

   assign bcast_wr = (o_addr == I3C_BCAST_ADDR) && !o_rnw;

   // Responder FSM with registered outputs and pulses
   always_ff @(posedge i_sdr_clk) begin
      if (!i_sdr_rst_n) begin
         state           <= ST_IDLE;
         cnt             <= '0;
         shreg           <= '0;
         o_sda_pull_low  <= 1'b0;
         o_start_det     <= 1'b0;
         o_stop_det      <= 1'b0;
         o_addr_valid    <= 1'b0;
         o_addr          <= '0;
         o_rnw           <= 1'b0;
         o_ccc_valid     <= 1'b0;
         o_ccc_code      <= '0;
         o_parity_err    <= 1'b0;
         o_hdr_ddr_enter <= 1'b0;
         o_in_hdr        <= 1'b0;
      end else begin
         o_start_det     <= 1'b0;
         o_stop_det      <= 1'b0;
         o_addr_valid    <= 1'b0;
         o_ccc_valid     <= 1'b0;
         o_parity_err    <= 1'b0;
         o_hdr_ddr_enter <= 1'b0;
         if (!i_tgt_en) begin
            state          <= ST_IDLE;
            o_sda_pull_low <= 1'b0;
            o_in_hdr       <= 1'b0;
         end else if (state == ST_HDR) begin
            if (i_hdr_exit) begin
               state    <= ST_IDLE;
               o_in_hdr <= 1'b0;
            end
         end else if (start) begin
            o_start_det    <= 1'b1;
            o_sda_pull_low <= 1'b0;
            state          <= ST_ADDR;
            cnt            <= '0;
         end else if (stop) begin
            o_stop_det     <= 1'b1;
            o_sda_pull_low <= 1'b0;
            state          <= ST_IDLE;
         end else begin
            unique case (state)
               ST_ADDR: begin
                  if (scl_rise) begin
                     shreg <= {shreg[6:0], sda};
                     cnt   <= cnt + 4'd1;
                  end else if (scl_fall && cnt == 4'd8) begin
                     o_addr <= shreg[7:1];
                     o_rnw  <= shreg[0];
                     if (match) begin
                        state          <= ST_ACK;
                        o_sda_pull_low <= 1'b1;
                     end else begin
                        state <= ST_WAIT_STOP;
                     end
                  end
               end
               ST_ACK: begin
                  if (scl_rise) begin
                     cnt <= 4'd9;
                  end else if (scl_fall && cnt == 4'd9) begin
                     o_sda_pull_low <= 1'b0;
                     o_addr_valid   <= 1'b1;
                     if (bcast_wr) begin
                        state <= ST_CCC;
                        cnt   <= '0;
                     end else begin
                        state <= ST_WAIT_STOP;
                     end
                  end
               end
               ST_CCC: begin
                  if (scl_rise) begin
                     shreg <= {shreg[6:0], sda};
                     cnt   <= cnt + 4'd1;
                     if (cnt == 4'd7) state <= ST_TBIT;
                  end
               end
               ST_TBIT: begin
                  if (scl_rise) begin
                     if (tbit_ok(shreg, sda)) begin
                        o_ccc_valid <= 1'b1;
                        o_ccc_code  <= shreg;
                        if (shreg == ENTHDR0_CODE) begin
                           o_hdr_ddr_enter <= 1'b1;
                           o_in_hdr        <= 1'b1;
                           state           <= ST_HDR;
                        end else begin
                           state <= ST_WAIT_STOP;
                        end
                     end else begin
                        o_parity_err <= 1'b1;
                        state        <= ST_WAIT_STOP;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
